// File: rtl/mem_stage_dmem.sv
// MIPS MEM-stage data memory: byte/half/word loads and stores with a fixed LATENCY-cycle access.
// MemStall freezes the front of the pipeline while an access is in flight; MemRDM is valid in DONE.
module mem_stage_dmem #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUResM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] MemRDM,
    output logic        MemStall,
    output logic        MemAddrErr
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state;
    logic [3:0]          cnt;
    logic [31:0]         mem [0:(1<<ADDR_W)-1];

    logic                req;
    logic                misaligned;
    logic [ADDR_W-1:0]   widx;
    logic [31:0]         rword;
    logic [7:0]          rbyte;
    logic [15:0]         rhalf;
    logic [31:0]         rext;
    logic [3:0]          be;
    logic [31:0]         wlanes;
    logic [31:0]         wmerge;
    logic                unused_addr;

    // Upper address bits are deliberately dropped so addresses wrap.
    assign unused_addr = ^ALUResM[31:ADDR_W+2];

    always_comb begin
        req        = MemReadM | MemWriteM;
        widx       = ALUResM[ADDR_W+1:2];
        rword      = mem[widx];
        rbyte      = rword[{ALUResM[1:0], 3'b000} +: 8];
        rhalf      = rword[{ALUResM[1], 4'b0000} +: 16];
        misaligned = 1'b0;
        rext       = rword;
        be         = 4'b1111;
        wlanes     = WriteDataM;
        case (MemSizeM)
            2'b00: begin
                rext   = {{24{MemSignedM & rbyte[7]}}, rbyte};
                be     = 4'b0001 << ALUResM[1:0];
                wlanes = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                misaligned = ALUResM[0];
                rext       = {{16{MemSignedM & rhalf[15]}}, rhalf};
                be         = ALUResM[1] ? 4'b1100 : 4'b0011;
                wlanes     = {2{WriteDataM[15:0]}};
            end
            default: misaligned = (ALUResM[1:0] != 2'b00);
        endcase
        for (int i = 0; i < 4; i++) begin
            wmerge[8*i +: 8] = be[i] ? wlanes[8*i +: 8] : rword[8*i +: 8];
        end
        MemAddrErr = req & misaligned;
        MemStall   = ((state == IDLE) & req & ~misaligned) | (state == BUSY);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            MemRDM <= 32'd0;
        end else begin
            case (state)
                IDLE: if (req && !misaligned) begin
                    cnt   <= 4'(LATENCY - 1);
                    state <= BUSY;
                end
                BUSY: if (cnt == 4'd0) begin
                    state <= DONE;
                    if (MemReadM) MemRDM <= rext;
                end else begin
                    cnt <= cnt - 4'd1;
                end
                // The request still visible in DONE is the finished instruction; never re-accept it here.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Store commits on the DONE->IDLE edge only; a reset in flight drops it.
    always_ff @(posedge clk) begin
        if (!reset && state == DONE && MemWriteM) mem[widx] <= wmerge;
    end
endmodule

// File: tb/tb_mem_stage_dmem.sv
// Directed bench for mem_stage_dmem: load results go through an expected-value queue popped in DONE.
module tb_mem_stage_dmem;
    localparam int AW  = 10;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM, MemSignedM;
    logic [1:0]  MemSizeM;
    logic [31:0] ALUResM, WriteDataM;
    logic [31:0] MemRDM;
    logic        MemStall, MemAddrErr;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_rd;
    logic [31:0] pre_commit;

    mem_stage_dmem #(.ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .MemSizeM(MemSizeM),
        .MemSignedM(MemSignedM), .ALUResM(ALUResM), .WriteDataM(WriteDataM),
        .MemRDM(MemRDM), .MemStall(MemStall), .MemAddrErr(MemAddrErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic sg, input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        MemSizeM   = sz;
        MemSignedM = sg;
        ALUResM    = addr;
        WriteDataM = wd;
    endtask

    task automatic idle_in();
        MemReadM  = 1'b0;
        MemWriteM = 1'b0;
    endtask

    // Called at posedge+1 with the FSM in IDLE; returns at posedge+1 just after DONE->IDLE.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] exp);
        int stalls;
        logic [31:0] e;
        drive(rd, wr, sz, sg, addr, wd);
        if (rd) exp_q.push_back(exp);
        stalls = 0;
        @(negedge clk);
        while (MemStall && stalls < 40) begin
            stalls++;
            @(negedge clk);
        end
        chk({tag, "_stalls"}, 32'(stalls), 32'(LAT + 1));
        chk({tag, "_err"}, {31'd0, MemAddrErr}, 32'd0);
        pre_commit = dut.mem[addr[AW+1:2]];
        if (rd) begin
            e = exp_q.pop_front();
            chk({tag, "_rdata"}, MemRDM, e);
            last_rd = e;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic misal(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic [31:0] addr);
        drive(rd, wr, sz, 1'b0, addr, 32'hFFFF_FFFF);
        @(negedge clk);
        chk({tag, "_err"}, {31'd0, MemAddrErr}, 32'd1);
        chk({tag, "_stall"}, {31'd0, MemStall}, 32'd0);
        chk({tag, "_rdm"}, MemRDM, last_rd);
        @(negedge clk);
        chk({tag, "_stall2"}, {31'd0, MemStall}, 32'd0);
        @(posedge clk);
        #1;
        idle_in();
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0);
        last_rd = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Array has no reset; give the words under test a known zero.
        access("z00", 1'b0, 1'b1, 2'b10, 1'b0, 32'h00, 32'd0, 32'd0);
        access("z10", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 32'd0);
        access("z14", 1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'd0, 32'd0);
        access("z20", 1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'd0, 32'd0);
        idle_in();

        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_stall", {31'd0, MemStall}, 32'd0);
        chk("rst_rdm", MemRDM, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        access("rd0", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'd0, 32'h0000_0000);
        idle_in();

        access("sw10", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'd0);
        idle_in();
        chk("sw10_precommit", pre_commit, 32'd0);
        @(negedge clk);
        chk("sw10_commit", dut.mem[4], 32'hDEAD_BEEF);
        chk("sw10_noretrig", {31'd0, MemStall}, 32'd0);
        @(posedge clk);
        #1;
        access("lw10", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEAD_BEEF);
        idle_in();

        access("sb11", 1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAA_AA7F, 32'd0);
        access("lw10b", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEAD_7FEF);
        access("lbs13", 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'd0, 32'hFFFF_FFDE);
        access("lhu12", 1'b1, 1'b0, 2'b01, 1'b0, 32'h12, 32'd0, 32'h0000_DEAD);
        access("sh16", 1'b0, 1'b1, 2'b01, 1'b0, 32'h16, 32'h5555_8001, 32'd0);
        access("lhs16", 1'b1, 1'b0, 2'b01, 1'b1, 32'h16, 32'd0, 32'hFFFF_8001);
        access("lbu17", 1'b1, 1'b0, 2'b00, 1'b0, 32'h17, 32'd0, 32'h0000_0080);
        access("lw14", 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'h8001_0000);
        idle_in();

        misal("lh13", 1'b1, 1'b0, 2'b01, 32'h13);
        misal("lw12", 1'b1, 1'b0, 2'b10, 32'h12);
        misal("sw12", 1'b0, 1'b1, 2'b10, 32'h12);
        chk("misal_mem", dut.mem[4], 32'hDEAD_7FEF);

        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0123, 32'h0BAD_0BAD);
        @(negedge clk);
        chk("nomem_stall", {31'd0, MemStall}, 32'd0);
        chk("nomem_rdm", MemRDM, last_rd);
        @(posedge clk);
        #1;

        // Store aborted by reset in its first BUSY cycle.
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1234_5678);
        @(negedge clk);
        chk("abort_accept", {31'd0, MemStall}, 32'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        idle_in();
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("abort_stall", {31'd0, MemStall}, 32'd0);
        chk("abort_rdm", MemRDM, 32'd0);
        last_rd = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_mem", dut.mem[8], 32'd0);
        access("lw20", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'd0, 32'h0000_0000);
        idle_in();

        // Aliased address followed directly by more loads.
        access("lw1010", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'd0, 32'hDEAD_7FEF);
        access("b2b_lw", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 32'hDEAD_7FEF);
        access("b2b_lb", 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'd0, 32'h0000_00EF);
        idle_in();
        access("sw1014", 1'b0, 1'b1, 2'b10, 1'b0, 32'hFFFF_1014, 32'hCAFE_F00D, 32'd0);
        idle_in();
        access("lw14w", 1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 32'hCAFE_F00D);
        idle_in();
        @(negedge clk);
        chk("final_idle", {31'd0, MemStall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
